// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I main controller: sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Latency: branch 3, R/I/store/jal/lui 4, load 5 cycles at zero wait; +1 per cycle mem_ready_i is low in a memory state.
// Backpressure: mem_req_o/mem_we_o/adr_src_o hold steady until mem_ready_i; the FSM stalls in place meanwhile.
//
// Ports: clk, reset (async active-low); opcode_i (IR[6:0]); mem_ready_i; branch_taken_i;
//        memory controls mem_req_o/mem_we_o/adr_src_o; write enables ir_write_o/pc_write_o/reg_write_o;
//        ALU selects alu_src_a_o/alu_src_b_o/alu_op_o; result_src_o; imm_src_o; state_o (debug); illegal_o.
module multicycle_control_unit #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode_i,
    input  logic               mem_ready_i,
    input  logic               branch_taken_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               adr_src_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic               reg_write_o,
    output logic [1:0]         alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [1:0]         alu_op_o,
    output logic [1:0]         result_src_o,
    output logic [2:0]         imm_src_o,
    output logic [STATE_W-1:0] state_o,
    output logic               illegal_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_LUI       = 4'd11,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t state_q, state_d;

    // Ungated control values; the output stage masks them while reset is low.
    logic       mem_req_c, mem_we_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c, illegal_c;
    logic [1:0] alu_a_c, alu_b_c, alu_op_c, result_c;
    logic [2:0] imm_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        adr_src_c   = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        alu_a_c     = 2'b00;
        alu_b_c     = 2'b00;
        alu_op_c    = 2'b00;
        result_c    = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                alu_b_c   = 2'b10;
                result_c  = 2'b10;
                // IR load and PC+4 happen only in the cycle memory returns the word.
                ir_write_c = mem_ready_i;
                pc_write_c = mem_ready_i;
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jump target (old PC + imm) lands in the ALU-out register here.
                alu_a_c = 2'b01;
                alu_b_c = 2'b01;
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_a_c = 2'b10;
                alu_b_c = 2'b01;
                if (opcode_i == OP_LOAD)       state_d = S_MEM_READ;
                else if (opcode_i == OP_STORE) state_d = S_MEM_WRITE;
                else                           state_d = S_TRAP;
            end
            S_MEM_READ: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_c    = 2'b01;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_a_c  = 2'b10;
                alu_op_c = 2'b10;
                state_d  = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_a_c  = 2'b10;
                alu_b_c  = 2'b01;
                alu_op_c = 2'b10;
                state_d  = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                // ALU compares rs1/rs2 for the condition block; PC takes the target saved in DECODE.
                alu_a_c    = 2'b10;
                alu_op_c   = 2'b01;
                pc_write_c = branch_taken_i;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // PC <- target from ALU-out; ALU meanwhile forms old PC + 4 as the link value.
                alu_a_c    = 2'b01;
                alu_b_c    = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_ALU_WB;
            end
            S_LUI: begin
                alu_a_c = 2'b11;
                alu_b_c = 2'b01;
                state_d = S_ALU_WB;
            end
            S_TRAP: begin
                illegal_c = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    always_comb begin
        case (opcode_i)
            OP_LOAD, OP_ITYPE: imm_c = 3'b000;
            OP_STORE:          imm_c = 3'b001;
            OP_BRANCH:         imm_c = 3'b010;
            OP_JAL:            imm_c = 3'b011;
            OP_LUI:            imm_c = 3'b100;
            default:           imm_c = 3'b000;
        endcase
    end

    // Reset masks outputs combinationally so FETCH's request does not leak out during reset.
    assign mem_req_o    = reset & mem_req_c;
    assign mem_we_o     = reset & mem_we_c;
    assign adr_src_o    = reset & adr_src_c;
    assign ir_write_o   = reset & ir_write_c;
    assign pc_write_o   = reset & pc_write_c;
    assign reg_write_o  = reset & reg_write_c;
    assign illegal_o    = reset & illegal_c;
    assign alu_src_a_o  = reset ? alu_a_c  : 2'b00;
    assign alu_src_b_o  = reset ? alu_b_c  : 2'b00;
    assign alu_op_o     = reset ? alu_op_c : 2'b00;
    assign result_src_o = reset ? result_c : 2'b00;
    assign imm_src_o    = reset ? imm_c    : 3'b000;
    assign state_o      = STATE_W'(state_q);

endmodule
